// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM sprite DMA engine.
//   dma_state_t  : transfer sequencer states
//   DMA_REG_ADDR : CPU address whose write starts a transfer ($4014)
//   OAMDATA_ADDR : PPU register address targeted by each OAM write ($2004)
//   DMA_PAGE_BITS: width of the latched source page number
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE,
        DONE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR     = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;
    localparam int unsigned DMA_PAGE_BITS    = 8;
    localparam int unsigned XFER_LEN_DEFAULT = 256;

endpackage

// File: rtl/oam_dma.sv
// CPU-side sprite DMA engine. A CPU write to DMA_REG_ADDR copies one
// 256-byte CPU page into PPU OAM by repeated writes to OAMDATA, stalling
// the CPU for 513 cycles (even parity at HALT) or 514 cycles (odd parity).
//
// Ports (all on clk, the CPU clock):
//   clk           CPU clock
//   reset         synchronous, active-high
//   cpu_addr      CPU address bus
//   cpu_data_out  CPU write data (source page number on a trigger)
//   cpu_write     CPU write strobe, meaningful only while stall=0
//   stall         holds the CPU; its bus outputs are ignored while high
//   dma_addr      source read address, holds its last value outside READ
//   dma_rd        source read request
//   dma_data_in   source read data, valid the cycle after dma_rd
//   oam_wr        one-cycle write strobe toward the PPU register port
//   oam_addr      OAMDATA_ADDR while oam_wr=1, else 0
//   oam_data      byte written to OAMDATA, holds the last byte otherwise
//   busy          transfer in progress
//   done          one-cycle pulse after the last OAM write
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = oam_dma_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAMDATA_ADDR = oam_dma_pkg::OAMDATA_ADDR,
    // Power of two, at most 256.
    parameter int unsigned XFER_LEN     = oam_dma_pkg::XFER_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_write,
    output logic        stall,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_data_in,
    output logic        oam_wr,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_data,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t               state_q,    state_d;
    logic                     parity_q;
    logic [DMA_PAGE_BITS-1:0] page_q,     page_d;
    logic [7:0]               idx_q,      idx_d;
    logic [15:0]              dma_addr_q, dma_addr_d;
    logic [7:0]               oam_data_q, oam_data_d;
    logic                     trigger;

    assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            parity_q   <= 1'b0;
            page_q     <= '0;
            idx_q      <= '0;
            dma_addr_q <= '0;
            oam_data_q <= '0;
        end else begin
            state_q    <= state_d;
            parity_q   <= ~parity_q;
            page_q     <= page_d;
            idx_q      <= idx_d;
            dma_addr_q <= dma_addr_d;
            oam_data_q <= oam_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        dma_addr_d = dma_addr_q;
        oam_data_d = oam_data_q;

        stall    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        dma_rd   = 1'b0;
        oam_wr   = 1'b0;
        oam_addr = '0;
        dma_addr = dma_addr_q;
        oam_data = oam_data_q;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = cpu_data_out;
                    state_d = HALT;
                end
            end

            HALT: begin
                stall = 1'b1;
                busy  = 1'b1;
                // An odd cycle here costs one extra alignment cycle so that
                // reads land on the same phase as the CPU's own reads.
                state_d = parity_q ? ALIGN : READ;
            end

            ALIGN: begin
                stall   = 1'b1;
                busy    = 1'b1;
                state_d = READ;
            end

            READ: begin
                stall      = 1'b1;
                busy       = 1'b1;
                dma_rd     = 1'b1;
                dma_addr   = {page_q, idx_q};
                dma_addr_d = {page_q, idx_q};
                state_d    = WRITE;
            end

            WRITE: begin
                stall      = 1'b1;
                busy       = 1'b1;
                oam_wr     = 1'b1;
                oam_addr   = OAMDATA_ADDR;
                // Read data is forwarded straight through and also kept so
                // oam_data holds the last byte between writes.
                oam_data   = dma_data_in;
                oam_data_d = dma_data_in;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end

            DONE: begin
                done  = 1'b1;
                idx_d = '0;
                // CPU is released this cycle, so a fresh $4014 write is live.
                if (trigger) begin
                    page_d  = cpu_data_out;
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write;
    logic        stall;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_data_in = 8'h00;
    logic        oam_wr;
    logic [15:0] oam_addr;
    logic [7:0]  oam_data;
    logic        busy;
    logic        done;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        exp_par  = 1'b0;

    always #5 clk = ~clk;

    oam_dma #(
        .DMA_REG_ADDR(16'h4014),
        .OAMDATA_ADDR(16'h2004),
        .XFER_LEN    (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_write   (cpu_write),
        .stall       (stall),
        .dma_addr    (dma_addr),
        .dma_rd      (dma_rd),
        .dma_data_in (dma_data_in),
        .oam_wr      (oam_wr),
        .oam_addr    (oam_addr),
        .oam_data    (oam_data),
        .busy        (busy),
        .done        (done)
    );

    // Source memory model: content is a fixed function of the address.
    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (dma_rd) dma_data_in <= ram_byte(dma_addr);
    end

    // Reference parity: cleared by reset, toggles on every other edge.
    always @(posedge clk) begin
        exp_par <= reset ? 1'b0 : ~exp_par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; drives a $4014 write so the
    // following HALT cycle has parity want_par.
    task automatic align_trigger(input logic [7:0] pg, input logic want_par);
        if (exp_par == want_par) @(negedge clk);
        cpu_addr     = 16'h4014;
        cpu_data_out = pg;
        cpu_write    = 1'b1;
    endtask

    // Follows one transfer from HALT to DONE; returns at the DONE negedge.
    // With abort_at>0, asserts reset right after that many OAM writes.
    task automatic run_xfer(input logic [7:0] pg, input int unsigned abort_at,
                            input logic chain, input logic [7:0] nxt_pg);
        int unsigned ncyc, n_stall, n_rd, n_wr;
        logic odd, fin;
        @(negedge clk);
        cpu_write    = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_data_out = 8'h00;
        odd = exp_par;
        chk("halt_state", {28'd0, busy, stall, dma_rd, oam_wr}, 32'hC);
        n_stall = 1; n_rd = 0; n_wr = 0; ncyc = 0; fin = 1'b0;
        while (!fin && ncyc < 600) begin
            @(negedge clk);
            ncyc++;
            if (stall) n_stall++;
            if (dma_rd) begin
                if (n_rd == 0) chk("first_rd_delay", ncyc, odd ? 2 : 1);
                chk("rd_addr", {16'd0, dma_addr}, {16'd0, pg, n_rd[7:0]});
                n_rd++;
            end
            if (oam_wr) begin
                chk("wr_addr", {16'd0, oam_addr}, 32'h2004);
                chk("wr_data", {24'd0, oam_data}, {24'd0, ram_byte({pg, n_wr[7:0]})});
                n_wr++;
                if (abort_at != 0 && n_wr == abort_at) begin
                    reset = 1'b1;
                    return;
                end
            end
            if (done) begin
                fin = 1'b1;
                chk("done_released", {30'd0, busy, stall}, 32'd0);
            end
        end
        chk("done_seen", {31'd0, fin}, 32'd1);
        chk("stall_len", n_stall, odd ? 514 : 513);
        chk("rd_count", n_rd, 256);
        chk("wr_count", n_wr, 256);
        if (chain) begin
            cpu_addr     = 16'h4014;
            cpu_data_out = nxt_pg;
            cpu_write    = 1'b1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {27'd0, stall, busy, dma_rd, oam_wr, done}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        cpu_addr     = 16'h0000;
        cpu_data_out = 8'h00;
        cpu_write    = 1'b0;

        repeat (2) @(negedge clk);
        chk_idle("rst_ctrl");
        chk("rst_dma_addr", {16'd0, dma_addr}, 32'd0);
        chk("rst_oam", {oam_addr, 8'd0, oam_data}, 32'd0);

        // Trigger while reset is held: reset wins.
        cpu_addr = 16'h4014; cpu_data_out = 8'h02; cpu_write = 1'b1;
        @(negedge clk);
        chk_idle("rst_beats_trigger");
        cpu_write = 1'b0; cpu_addr = 16'h0000;
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        // Non-triggers: write elsewhere, then non-write to $4014.
        cpu_addr = 16'h4015; cpu_data_out = 8'h02; cpu_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("non_trigger");
            if (i == 0) begin
                cpu_addr  = 16'h4014;
                cpu_write = 1'b0;
            end
        end

        // Even parity at HALT.
        align_trigger(8'h02, 1'b0);
        run_xfer(8'h02, 0, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle("even_after");
        chk("even_addr_hold", {16'd0, dma_addr}, 32'h02FF);
        chk("even_data_hold", {24'd0, oam_data}, {24'd0, ram_byte(16'h02FF)});

        // Odd parity at HALT.
        align_trigger(8'h02, 1'b1);
        run_xfer(8'h02, 0, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle("odd_after");

        // Back-to-back: new trigger in the DONE cycle.
        align_trigger(8'h05, 1'b0);
        run_xfer(8'h05, 0, 1'b1, 8'h07);
        run_xfer(8'h07, 0, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle("b2b_after");
        chk("b2b_addr_hold", {16'd0, dma_addr}, 32'h07FF);

        // Reset mid-transfer after 100 OAM writes.
        align_trigger(8'h03, 1'b0);
        run_xfer(8'h03, 100, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        chk_idle("abort_idle");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle("abort_quiet");
        end
        align_trigger(8'h03, 1'b0);
        run_xfer(8'h03, 0, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle("restart_after");

        // Top page: no wrap past $FFFF.
        align_trigger(8'hFF, 1'b1);
        run_xfer(8'hFF, 0, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle("top_after");
        chk("top_addr_hold", {16'd0, dma_addr}, 32'hFFFF);
        chk("top_data_hold", {24'd0, oam_data}, {24'd0, ram_byte(16'hFFFF)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side sprite DMA engine: CPU write to $4014 copies one 256-byte CPU page into PPU OAM through OAMDATA ($2004).
- Sits between the CPU bus/work-RAM decode and the PPU register port, on the CPU clock domain (clk_CPU).
- Stalls the CPU for the transfer and drives the bus as master: 513 or 514 cycles, parity dependent.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAMDATA_ADDR, 16'h2004, PPU register address driven on each OAM write.
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256.

Ports:
- clk  in  1  CPU clock (clk_CPU).
- reset  in  1  synchronous, active-high.
- cpu_addr  in  16  CPU address bus.
- cpu_data_out  in  8  CPU write data.
- cpu_write  in  1  CPU write strobe; valid when stall=0.
- stall  out  1  halts CPU; CPU bus outputs ignored while high.
- dma_addr  out  16  DMA source read address.
- dma_rd  out  1  DMA source read request.
- dma_data_in  in  8  source read data; valid one cycle after dma_rd.
- oam_wr  out  1  one-cycle write strobe toward PPU register port.
- oam_addr  out  16  equals OAMDATA_ADDR while oam_wr=1, else 0.
- oam_data  out  8  byte written to OAMDATA.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last OAM write.

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; page=0; idx=0; parity=0.
- parity: free-running bit, cleared by reset, toggles every clk regardless of state.
- Trigger: in IDLE, cpu_write=1 and cpu_addr==DMA_REG_ADDR in cycle T latches page=cpu_data_out; state becomes HALT at T+1.
- Other addresses, or cpu_write=0, have no effect.
- Triggers while busy=1 are ignored; the CPU is stalled, so its bus is not sampled.
- States:
  - IDLE: stall=0, busy=0; waits for trigger.
  - HALT: one cycle, stall=1, busy=1. Next state is ALIGN if parity==1 in this cycle, else READ.
  - ALIGN: one dummy cycle, no bus activity; next state READ.
  - READ: dma_rd=1, dma_addr={page, idx[7:0]}; next state WRITE.
  - WRITE: capture dma_data_in into oam_data combinationally for this cycle; oam_wr=1, oam_addr=OAMDATA_ADDR. If idx==XFER_LEN-1, next state DONE, else idx increments and next state is READ.
  - DONE: one cycle, stall=0, busy=0, done=1, idx cleared; next state IDLE. A $4014 write in this cycle is accepted as a new trigger.
- stall=1 in HALT, ALIGN, READ and WRITE.
- Stall length: 513 cycles with parity 0 at HALT, 514 with parity 1.
- idx is 8 bits and never wraps mid-transfer; the terminal test is on idx, not on overflow.
- dma_addr holds its last value outside READ; dma_rd=0 outside READ.
- oam_data holds its last written byte when oam_wr=0.
- Reset mid-transfer: next cycle IDLE, stall=0, no further oam_wr, done not pulsed. OAM keeps its partial contents.
- Simultaneous reset and trigger: reset wins.

Decomposition:
- Shared package (alongside Games): typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE, DONE}; constants DMA_REG_ADDR and OAMDATA_ADDR; localparam DMA_PAGE_BITS=8.
- Single module; no sub-module. An address/byte counter is too small to split out.

Test Plan:
- Even parity: trigger with data 8'h02 at parity 0 at HALT -> stall high 513 cycles; dma_addr sequence 16'h0200..16'h02FF; 256 oam_wr pulses, each oam_data = model RAM byte; one done pulse; stall low after.
- Odd parity: same trigger at parity 1 at HALT -> stall 514 cycles; first dma_rd exactly 2 cycles after HALT; data identical.
- Non-triggers: write to 16'h4015 and read of 16'h4014 (cpu_write=0) -> stall, busy and oam_wr stay 0.
- Reset mid-transfer: assert reset after 100 oam_wr pulses -> next cycle stall=0, busy=0, no more oam_wr, no done; a new 8'h03 trigger then runs a full 16'h0300..16'h03FF transfer.
- Back-to-back: trigger 8'h07 in the DONE cycle of a prior transfer -> second transfer starts the next cycle with HALT; page 16'h0700 read correctly.
- Boundary page: trigger 8'hFF -> addresses 16'hFF00..16'hFFFF, no wrap into 16'h0000; last oam_wr carries RAM[16'hFFFF].
